// File: rtl/sub_bytes.sv
// sub_bytes -- AES-128 SubBytes stage.
//
// Applies the forward AES S-box to all 16 bytes of a 128-bit state. Each
// S-box is pure logic: map into GF((2^4)^2), invert there, map back and
// apply the AES affine transform.
//
// Composite field used here:
//   GF(2^4)     = GF(2)[y] / (y^4 + y + 1)
//   GF((2^4)^2) = GF(2^4)[x] / (x^2 + x + lambda), lambda = y^3 (4'h8)
//   byte layout {h, l} means h*x + l
//   The AES generator is mapped to beta = y*x (8'h20); the matrices below
//   are the columns beta^0..beta^7 and their inverse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, wins over in_valid
//   in_valid   state_in carries a state this cycle
//   state_in   byte k at [127-8k -: 8]
//   out_valid  state_out holds a newly produced result
//   state_out  substituted state, same byte order
//
// Build option: define SUB_BYTES_PIPE_EN to register the composite-field
// inverse before the back-mapping/affine logic (latency 2 instead of 1).
`timescale 1ns/1ps

module sub_bytes_sbox (
    input  logic [7:0] din,        // byte to substitute
    output logic [7:0] inv_cf,     // its inverse, composite-field basis
    input  logic [7:0] inv_cf_in,  // inverse to finish (direct or registered)
    output logic [7:0] dout        // S-box result for inv_cf_in
);
    // multiply by y, reduce by y^4 = y + 1
    function automatic logic [3:0] xt(input logic [3:0] t);
        return {t[2:0], 1'b0} ^ {2'b00, t[3], t[3]};
    endfunction

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] a1, a2, a3;
        a1 = xt(a);
        a2 = xt(a1);
        a3 = xt(a2);
        return ({4{b[0]}} & a) ^ ({4{b[1]}} & a1) ^ ({4{b[2]}} & a2) ^ ({4{b[3]}} & a3);
    endfunction

    function automatic logic [3:0] gf4_sq(input logic [3:0] z);
        return {z[3], z[3] ^ z[1], z[2], z[2] ^ z[0]};
    endfunction

    // z * y^3
    function automatic logic [3:0] gf4_lambda(input logic [3:0] z);
        return {z[3] ^ z[0], z[3] ^ z[2], z[2] ^ z[1], z[1]};
    endfunction

    // z^14 = z^-1, and 0 -> 0
    function automatic logic [3:0] gf4_inv(input logic [3:0] z);
        logic [3:0] z2, z4, z8;
        z2 = gf4_sq(z);
        z4 = gf4_sq(z2);
        z8 = gf4_sq(z4);
        return gf4_mul(gf4_mul(z8, z4), z2);
    endfunction

    function automatic logic [7:0] to_cf(input logic [7:0] a);
        return {a[5] ^ a[7],
                a[2] ^ a[3] ^ a[5] ^ a[7],
                a[1] ^ a[4] ^ a[6] ^ a[7],
                a[4] ^ a[5] ^ a[6],
                a[3] ^ a[4],
                a[2] ^ a[3] ^ a[4] ^ a[5] ^ a[6] ^ a[7],
                a[2],
                a[0] ^ a[5] ^ a[7]};
    endfunction

    function automatic logic [7:0] from_cf(input logic [7:0] q);
        return {q[2] ^ q[4] ^ q[6] ^ q[7],
                q[1] ^ q[2] ^ q[3] ^ q[7],
                q[2] ^ q[4] ^ q[6],
                q[1] ^ q[3] ^ q[6] ^ q[7],
                q[1] ^ q[6] ^ q[7],
                q[1],
                q[4] ^ q[5] ^ q[7],
                q[0] ^ q[7]};
    endfunction

    // (h*x + l)^-1 = (h*d^-1)*x + (h+l)*d^-1, d = lambda*h^2 + h*l + l^2
    function automatic logic [7:0] cf_inv(input logic [7:0] q);
        logic [3:0] h, l, d, di;
        h  = q[7:4];
        l  = q[3:0];
        d  = gf4_lambda(gf4_sq(h)) ^ gf4_mul(h, l) ^ gf4_sq(l);
        di = gf4_inv(d);
        return {gf4_mul(h, di), gf4_mul(h ^ l, di)};
    endfunction

    // b'_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ c_i, as rotations
    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[3:0], b[7:4]} ^ {b[4:0], b[7:5]} ^ {b[5:0], b[7:6]}
                 ^ {b[6:0], b[7]} ^ 8'h63;
    endfunction

    assign inv_cf = cf_inv(to_cf(din));
    assign dout   = affine(from_cf(inv_cf_in));
endmodule

module sub_bytes (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [127:0] state_in,
    output logic         out_valid,
    output logic [127:0] state_out
);
`ifdef SUB_BYTES_PIPE_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    logic [15:0][7:0] in_b, inv_b, inv_src, sub_b;
    logic [STAGES:1]  vld_pipe;
    logic             out_ld;

    assign in_b = state_in;

    for (genvar k = 0; k < 16; k++) begin : g_sbox
        sub_bytes_sbox u_sbox (
            .din       (in_b[k]),
            .inv_cf    (inv_b[k]),
            .inv_cf_in (inv_src[k]),
            .dout      (sub_b[k])
        );
    end

`ifdef SUB_BYTES_PIPE_EN
    logic [15:0][7:0] inv_q;

    always_ff @(posedge clk) begin
        if (rst)
            inv_q <= '0;
        else if (in_valid)
            inv_q <= inv_b;
    end

    assign inv_src = inv_q;
    assign out_ld  = vld_pipe[1];

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[1], in_valid};
    end
`else
    assign inv_src = inv_b;
    assign out_ld  = in_valid;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= in_valid;
    end
`endif

    // output only moves on a valid result; otherwise holds
    always_ff @(posedge clk) begin
        if (rst)
            state_out <= '0;
        else if (out_ld)
            state_out <= sub_b;
    end

    assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_sub_bytes.sv
`timescale 1ns/1ps

module tb_sub_bytes;
`ifdef SUB_BYTES_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] state_in;
    logic         out_valid;
    logic [127:0] state_out;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sub_bytes dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .state_in  (state_in),
        .out_valid (out_valid),
        .state_out (state_out)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // byte k = (i+k) mod 256
    function automatic logic [127:0] ramp_in(input int i);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v = {v[119:0], 8'(i + k)};
        return v;
    endfunction

    function automatic logic [127:0] ramp_exp(input int i);
        logic [127:0] v;
        logic [7:0]   idx;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            idx = 8'(i + k);
            v   = {v[119:0], SBOX[idx]};
        end
        return v;
    endfunction

    // one isolated state; checks result and valid after the pipeline latency
    task automatic do_vec(input string tag, input logic [127:0] d, input logic [127:0] e);
        in_valid = 1'b1;
        state_in = d;
        step();
        in_valid = 1'b0;
        for (int c = 1; c < LAT; c++) step();
        chk(tag, state_out, e);
        chk({tag, "_vld"}, {127'b0, out_valid}, 128'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int run;
        int max_run;
        int j;

        rst      = 1'b1;
        in_valid = 1'b0;
        state_in = '0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_data", state_out, 128'h0);
        chk("rst_vld", {127'b0, out_valid}, 128'd0);

        do_vec("fips_c1", 128'h00102030405060708090a0b0c0d0e0f0,
                          128'h63cab7040953d051cd60e0e7ba70e18c);
        do_vec("kungfu",  128'h001F0E543C4E08596E221B0B4774311A,
                          128'h63C0AB20EB2F30CB9F93AF2BA092C7A2);
        do_vec("zero",    {16{8'h00}}, {16{8'h63}});
        do_vec("ones",    {16{8'hff}}, {16{8'h16}});
        do_vec("x53",     {16{8'h53}}, {16{8'hed}});
        do_vec("x01",     {16{8'h01}}, {16{8'h7c}});

        // in_valid low: output holds, valid drops
        step();
        chk("hold_data", state_out, {16{8'h7c}});
        chk("hold_vld", {127'b0, out_valid}, 128'd0);

        // back-to-back stream over every byte value in every lane
        run     = 0;
        max_run = 0;
        for (int c = 0; c < 256 + LAT; c++) begin
            if (c < 256) begin
                in_valid = 1'b1;
                state_in = ramp_in(c);
            end else begin
                in_valid = 1'b0;
            end
            step();
            j = c - (LAT - 1);
            if (j >= 0 && j < 256) chk($sformatf("ramp%0d", j), state_out, ramp_exp(j));
            if (out_valid) run++;
            else begin
                if (run > max_run) max_run = run;
                run = 0;
            end
        end
        if (run > max_run) max_run = run;
        chk("ramp_run", 128'(max_run), 128'd256);
        chk("ramp_hold", state_out, ramp_exp(255));
        chk("ramp_end_vld", {127'b0, out_valid}, 128'd0);

        // reset while a state is in flight and another is being offered
        in_valid = 1'b1;
        state_in = ramp_in(7);
        step();
        rst      = 1'b1;
        state_in = ramp_in(9);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_data", state_out, 128'h0);
        chk("mid_rst_vld", {127'b0, out_valid}, 128'd0);
        for (int c = 0; c < LAT; c++) begin
            step();
            chk($sformatf("stale%0d_data", c), state_out, 128'h0);
            chk($sformatf("stale%0d_vld", c), {127'b0, out_valid}, 128'd0);
        end
        do_vec("post_rst", 128'h00102030405060708090a0b0c0d0e0f0,
                           128'h63cab7040953d051cd60e0e7ba70e18c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
